any1_mem_align: RTL and testbench
=================================

ANY1_MEM_ALIGN -- requirements
Module: any1_mem_align

Interface
REQ-001 SHALL have parameter AWID, default 32, address width in bits.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_i  input  1  memory-op request from the pipeline.
REQ-005 SHALL have port ready_o  output  1  block idle and able to accept req_i.
REQ-006 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port adr_i  input  AWID  byte address of access.
REQ-008 SHALL have port sel_i  input  8  unshifted byte lane select (01, 03, 0F, FF, or 00) from the select stage.
REQ-009 SHALL have port sext_i  input  1  sign-extend load result.
REQ-010 SHALL have port wdat_i  input  64  store data, right-aligned.
REQ-011 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err_o  output  1  bus error flag, valid with done_o.
REQ-013 SHALL have port rdat_o  output  64  load result, right-aligned, extended; held until next done_o.
REQ-014 SHALL have ports cyc_o, stb_o, we_o  output  1 each  bus cycle, strobe, write enable.
REQ-015 SHALL have port sel_o  output  8  bus byte lanes.
REQ-016 SHALL have port adr_o  output  AWID  bus address, bits [2:0] always 0.
REQ-017 SHALL have port dat_o  output  64  bus write data.
REQ-018 SHALL have ports ack_i, err_i  input  1 each; bus_dat_i  input  64  bus response.

Function
REQ-019 SHALL implement states IDLE, BUS1, BUS2, FIN; ready_o = 1 only in IDLE.
REQ-020 SHALL, in IDLE with req_i=1, latch we_i, adr_i, sel_i, sext_i, wdat_i; compute sel16 = sel_i << adr_i[2:0] and wd128 = wdat_i << (8*adr_i[2:0]).
REQ-021 SHALL, on acceptance with sel_i = 0, go to FIN with no bus cycle, err_o = 0, rdat_o = 0.
REQ-022 SHALL, on acceptance with sel_i != 0, enter BUS1 next cycle with cyc_o=stb_o=1, we_o=we, sel_o=sel16[7:0], adr_o={adr[AWID-1:3],3'b0}, dat_o=wd128[63:0].
REQ-023 SHALL hold all bus outputs stable in BUS1/BUS2 until ack_i or err_i sampled high.
REQ-024 SHALL, on ack_i in BUS1 with sel16[15:8] != 0, enter BUS2 keeping cyc_o=stb_o=1, sel_o=sel16[15:8], adr_o=previous adr_o+8 (wrapping modulo 2^AWID), dat_o=wd128[127:64]; load data lo captured.
REQ-025 SHALL, on ack_i in BUS1 with sel16[15:8] = 0, or ack_i in BUS2, drop cyc_o/stb_o and enter FIN.
REQ-026 SHALL, on err_i (priority over ack_i) in BUS1 or BUS2, drop cyc_o/stb_o, skip BUS2, set err_o=1, enter FIN.
REQ-027 SHALL in FIN assert done_o for exactly one cycle and return to IDLE; a request may be accepted the following cycle.
REQ-028 SHALL form loads as ({hi,lo} >> 8*adr[2:0]) masked by byte mask from sel_i; hi = 0 when BUS2 not used.
REQ-029 SHALL, with sext_i=1, replicate bit 7/15/31 for sel_i 01/03/0F; no change for FF or sext_i=0.
REQ-030 SHALL leave rdat_o unchanged on stores and on err; err_o cleared at next acceptance.
REQ-031 SHALL ignore req_i outside IDLE; minimum latency req->done_o is 3 cycles (single bus cycle, ack in first strobe cycle).

Reset
REQ-032 SHALL, when rst_ni=0 at a clock edge, enter IDLE and drive cyc_o=stb_o=we_o=0, sel_o=0, adr_o=0, dat_o=0, done_o=0, err_o=0, rdat_o=0, aborting any bus cycle in progress.
REQ-033 SHALL accept no request in the cycle rst_ni is low.

Verification
REQ-034 Aligned load: adr=0x1000, sel=FF, bus_dat=0x1122334455667788, ack 1st cycle -> one bus cycle sel_o=FF adr_o=0x1000, done_o at cycle 3, rdat_o=0x1122334455667788.
REQ-035 Misaligned store: adr=0x1006, sel=0F, wdat=0xAABBCCDD -> cycle1 adr_o=0x1000 sel_o=C0 dat_o[63:48]=0xCCDD; cycle2 adr_o=0x1008 sel_o=03 dat_o[15:0]=0xAABB; single done_o.
REQ-036 Signed byte load: adr=0x2003, sel=01, sext=1, bus_dat byte3=0x80 -> rdat_o=0xFFFFFFFFFFFFFF80; with sext=0 -> 0x80.
REQ-037 Error: adr=0x3007, sel=03, err_i on first strobe -> no second cycle, done_o with err_o=1, rdat_o unchanged.
REQ-038 Reset mid-op: rst_ni=0 during BUS2 with ack_i withheld -> next cycle cyc_o=stb_o=0, ready_o=1, no done_o.
REQ-039 Zero select: sel=00 req -> no cyc_o, done_o 2 cycles after acceptance, rdat_o=0.

Source files
------------

// File: rtl/any1_mem_align.sv
`default_nettype none
// ============================================================================
// Module      : any1_mem_align
// Description : Memory access aligner. Accepts a byte-addressed load/store of
//               up to 8 bytes and turns it into one or two 64-bit aligned bus
//               cycles. Load data is re-assembled, right-aligned, masked and
//               optionally sign-extended.
// Revision    : 1.0 - initial release
//
// Ports
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   req_i / ready_o                request from pipeline / block idle
//   we_i, adr_i, sel_i, sext_i     access type, byte address, unshifted lanes,
//   wdat_i                         sign-extend flag, right-aligned store data
//   done_o, err_o, rdat_o          completion pulse, bus error, load result
//   cyc_o, stb_o, we_o, sel_o,     bus master outputs (adr_o is 8-byte aligned)
//   adr_o, dat_o
//   ack_i, err_i, bus_dat_i        bus response
// ============================================================================
module any1_mem_align #(
  parameter int AWID = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  output logic            ready_o,
  input  logic            we_i,
  input  logic [AWID-1:0] adr_i,
  input  logic [7:0]      sel_i,
  input  logic            sext_i,
  input  logic [63:0]     wdat_i,
  output logic            done_o,
  output logic            err_o,
  output logic [63:0]     rdat_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [7:0]      sel_o,
  output logic [AWID-1:0] adr_o,
  output logic [63:0]     dat_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic [63:0]     bus_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS1 = 2'd1,
    BUS2 = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic        we_r;
  logic [2:0]  off_r;
  logic [7:0]  sel_r;
  logic        sext_r;
  logic [7:0]  sel_hi_r;
  logic [63:0] wd_hi_r;
  logic [63:0] lo_r;
  logic [63:0] hi_r;
  logic        err_pend_r;

  logic        accept;
  logic [15:0] sel16;
  logic [127:0] wd128;
  logic [63:0] aligned;
  logic [63:0] byte_mask;
  logic [63:0] masked;
  logic [63:0] load_val;

  assign ready_o = (state == IDLE);
  assign accept  = (state == IDLE) && req_i;

  // Lane select and store data spread across two 8-byte words.
  assign sel16 = {8'h00, sel_i} << adr_i[2:0];
  assign wd128 = {64'h0, wdat_i} << {adr_i[2:0], 3'b000};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_i) state_nxt = (sel_i == 8'h00) ? FIN : BUS1;
      BUS1: begin
        if (err_i)      state_nxt = FIN;
        else if (ack_i) state_nxt = (sel_hi_r != 8'h00) ? BUS2 : FIN;
      end
      BUS2: if (err_i || ack_i) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- load path
  // Re-assemble the two bus words, shift the addressed bytes down to bit 0,
  // then keep only the lanes the access asked for.
  assign aligned = 64'({hi_r, lo_r} >> {off_r, 3'b000});

  always_comb begin
    byte_mask = 64'h0;
    for (int i = 0; i < 8; i++) begin
      byte_mask[i*8 +: 8] = {8{sel_r[i]}};
    end
  end

  assign masked = aligned & byte_mask;

  always_comb begin
    load_val = masked;
    if (sext_r) begin
      case (sel_r)
        8'h01:   load_val = {{56{masked[7]}},  masked[7:0]};
        8'h03:   load_val = {{48{masked[15]}}, masked[15:0]};
        8'h0F:   load_val = {{32{masked[31]}}, masked[31:0]};
        default: load_val = masked;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_r       <= 1'b0;
      off_r      <= 3'd0;
      sel_r      <= 8'h00;
      sext_r     <= 1'b0;
      sel_hi_r   <= 8'h00;
      wd_hi_r    <= 64'h0;
      lo_r       <= 64'h0;
      hi_r       <= 64'h0;
      err_pend_r <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      rdat_o     <= 64'h0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      sel_o      <= 8'h00;
      adr_o      <= '0;
      dat_o      <= 64'h0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_r       <= we_i;
            off_r      <= adr_i[2:0];
            sel_r      <= sel_i;
            sext_r     <= sext_i;
            sel_hi_r   <= sel16[15:8];
            wd_hi_r    <= wd128[127:64];
            lo_r       <= 64'h0;
            hi_r       <= 64'h0;   // stays zero unless a second cycle runs
            err_pend_r <= 1'b0;
            err_o      <= 1'b0;
            if (sel_i != 8'h00) begin
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              we_o  <= we_i;
              sel_o <= sel16[7:0];
              adr_o <= {adr_i[AWID-1:3], 3'b000};
              dat_o <= wd128[63:0];
            end
          end
        end
        BUS1: begin
          if (err_i) begin
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            sel_o      <= 8'h00;
            err_pend_r <= 1'b1;
          end else if (ack_i) begin
            lo_r <= bus_dat_i;
            if (sel_hi_r != 8'h00) begin
              sel_o <= sel_hi_r;
              adr_o <= adr_o + AWID'(8);   // wraps at the top of the space
              dat_o <= wd_hi_r;
            end else begin
              cyc_o <= 1'b0;
              stb_o <= 1'b0;
              we_o  <= 1'b0;
              sel_o <= 8'h00;
            end
          end
        end
        BUS2: begin
          if (err_i || ack_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            sel_o <= 8'h00;
            if (err_i) err_pend_r <= 1'b1;
            else       hi_r       <= bus_dat_i;
          end
        end
        FIN: begin
          done_o <= 1'b1;
          err_o  <= err_pend_r;
          if (sel_r == 8'h00)
            rdat_o <= 64'h0;
          else if (!we_r && !err_pend_r)
            rdat_o <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_any1_mem_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_any1_mem_align
// Description : Directed self-checking bench for any1_mem_align.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_any1_mem_align;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        ready_o;
  logic        we_i;
  logic [31:0] adr_i;
  logic [7:0]  sel_i;
  logic        sext_i;
  logic [63:0] wdat_i;
  logic        done_o;
  logic        err_o;
  logic [63:0] rdat_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [7:0]  sel_o;
  logic [31:0] adr_o;
  logic [63:0] dat_o;
  logic        ack_i;
  logic        err_i;
  logic [63:0] bus_dat_i;

  int vectors     = 0;
  int miscompares = 0;

  any1_mem_align #(.AWID(32)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .ready_o   (ready_o),
    .we_i      (we_i),
    .adr_i     (adr_i),
    .sel_i     (sel_i),
    .sext_i    (sext_i),
    .wdat_i    (wdat_i),
    .done_o    (done_o),
    .err_o     (err_o),
    .rdat_o    (rdat_o),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .sel_o     (sel_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .ack_i     (ack_i),
    .err_i     (err_i),
    .bus_dat_i (bus_dat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a request at the current negedge (block must be idle).
  task automatic start(input logic we, input logic [31:0] adr, input logic [7:0] sel,
                       input logic sext, input logic [63:0] wdat);
    chk("ready_idle", {63'h0, ready_o}, 64'h1);
    req_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; sext_i = sext; wdat_i = wdat;
    @(negedge clk_i);
    // Keep a conflicting request on the inputs; it must be ignored while busy.
    we_i = ~we; adr_i = 32'hDEAD_BEE0; sel_i = 8'hFF; wdat_i = 64'h0123_4567_89AB_CDEF;
  endtask

  // One bus beat: check the strobe, optionally stall, then respond.
  task automatic beat(input string tag, input logic [31:0] eadr, input logic [7:0] esel,
                      input logic ewe, input logic [63:0] edat, input logic [63:0] dmask,
                      input logic [63:0] rd, input logic use_err, input int waits);
    chk({tag, "_cyc"},   {63'h0, cyc_o},   64'h1);
    chk({tag, "_stb"},   {63'h0, stb_o},   64'h1);
    chk({tag, "_ready"}, {63'h0, ready_o}, 64'h0);
    chk({tag, "_adr"},   {32'h0, adr_o},   {32'h0, eadr});
    chk({tag, "_sel"},   {56'h0, sel_o},   {56'h0, esel});
    chk({tag, "_we"},    {63'h0, we_o},    {63'h0, ewe});
    chk({tag, "_dat"},   dat_o & dmask,    edat);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk_i);
      chk({tag, "_hold_adr"}, {32'h0, adr_o}, {32'h0, eadr});
      chk({tag, "_hold_sel"}, {56'h0, sel_o}, {56'h0, esel});
      chk({tag, "_hold_cyc"}, {63'h0, cyc_o}, 64'h1);
    end
    ack_i = ~use_err; err_i = use_err; bus_dat_i = rd;
    @(negedge clk_i);
    ack_i = 1'b0; err_i = 1'b0; bus_dat_i = 64'h0;
  endtask

  // Called at the negedge of the FIN cycle.
  task automatic finish(input string tag, input logic exp_err, input logic [63:0] exp_rdat);
    req_i = 1'b0;
    chk({tag, "_fin_cyc"},  {63'h0, cyc_o},  64'h0);
    chk({tag, "_fin_done"}, {63'h0, done_o}, 64'h0);
    @(negedge clk_i);
    chk({tag, "_done"}, {63'h0, done_o}, 64'h1);
    chk({tag, "_err"},  {63'h0, err_o},  {63'h0, exp_err});
    chk({tag, "_rdat"}, rdat_o, exp_rdat);
    @(negedge clk_i);
    chk({tag, "_done_once"}, {63'h0, done_o}, 64'h0);
    chk({tag, "_rdat_hold"}, rdat_o, exp_rdat);
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; adr_i = 32'h1000; sel_i = 8'hFF;
    sext_i = 1'b0; wdat_i = 64'h0; ack_i = 1'b0; err_i = 1'b0; bus_dat_i = 64'h0;
    repeat (3) @(negedge clk_i);
    // Reset state (request held high during reset must not be taken)
    chk("rst_cyc",   {63'h0, cyc_o},   64'h0);
    chk("rst_stb",   {63'h0, stb_o},   64'h0);
    chk("rst_sel",   {56'h0, sel_o},   64'h0);
    chk("rst_adr",   {32'h0, adr_o},   64'h0);
    chk("rst_dat",   dat_o,            64'h0);
    chk("rst_done",  {63'h0, done_o},  64'h0);
    chk("rst_err",   {63'h0, err_o},   64'h0);
    chk("rst_rdat",  rdat_o,           64'h0);
    chk("rst_ready", {63'h0, ready_o}, 64'h1);
    req_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Aligned doubleword load
    start(1'b0, 32'h1000, 8'hFF, 1'b0, 64'h0);
    beat("ald", 32'h1000, 8'hFF, 1'b0, 64'h0, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 0);
    finish("ald", 1'b0, 64'h1122_3344_5566_7788);

    // Misaligned word store split over two beats, first one stalled
    start(1'b1, 32'h1006, 8'h0F, 1'b0, 64'hAABB_CCDD);
    beat("st1", 32'h1000, 8'hC0, 1'b1, 64'hCCDD_0000_0000_0000, 64'hFFFF_0000_0000_0000, 64'h0, 1'b0, 2);
    beat("st2", 32'h1008, 8'h03, 1'b1, 64'h0000_0000_0000_AABB, 64'h0000_0000_0000_FFFF, 64'h0, 1'b0, 0);
    finish("st", 1'b0, 64'h1122_3344_5566_7788);

    // Signed byte load, then unsigned
    start(1'b0, 32'h2003, 8'h01, 1'b1, 64'h0);
    beat("lbs", 32'h2000, 8'h08, 1'b0, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 0);
    finish("lbs", 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    start(1'b0, 32'h2003, 8'h01, 1'b0, 64'h0);
    beat("lbu", 32'h2000, 8'h08, 1'b0, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 0);
    finish("lbu", 1'b0, 64'h0000_0000_0000_0080);

    // Signed word load crossing an 8-byte boundary
    start(1'b0, 32'h4005, 8'h0F, 1'b1, 64'h0);
    beat("lwx1", 32'h4000, 8'hE0, 1'b0, 64'h0, 64'h0, 64'h8877_6655_4433_2211, 1'b0, 0);
    beat("lwx2", 32'h4008, 8'h01, 1'b0, 64'h0, 64'h0, 64'h0000_0000_0000_00F0, 1'b0, 1);
    finish("lwx", 1'b0, 64'hFFFF_FFFF_F088_7766);

    // Signed halfword load with a clear sign bit
    start(1'b0, 32'h2006, 8'h03, 1'b1, 64'h0);
    beat("lhs", 32'h2000, 8'hC0, 1'b0, 64'h0, 64'h0, 64'h7FFE_0000_0000_0000, 1'b0, 0);
    finish("lhs", 1'b0, 64'h0000_0000_0000_7FFE);

    // Bus error on the first of two beats
    start(1'b0, 32'h3007, 8'h03, 1'b0, 64'h0);
    beat("berr", 32'h3000, 8'h80, 1'b0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    finish("berr", 1'b1, 64'h0000_0000_0000_7FFE);

    // Zero select: no bus cycle, error flag cleared on acceptance
    start(1'b0, 32'h5000, 8'h00, 1'b0, 64'h0);
    chk("zsel_err_clr", {63'h0, err_o}, 64'h0);
    finish("zsel", 1'b0, 64'h0);

    // Reset while the second beat is stalled
    start(1'b0, 32'h1006, 8'h0F, 1'b0, 64'h0);
    beat("rmid1", 32'h1000, 8'hC0, 1'b0, 64'h0, 64'h0, 64'h1234_0000_0000_0000, 1'b0, 0);
    chk("rmid_bus2_cyc", {63'h0, cyc_o}, 64'h1);
    rst_ni = 1'b0; req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("rmid_cyc",   {63'h0, cyc_o},   64'h0);
    chk("rmid_stb",   {63'h0, stb_o},   64'h0);
    chk("rmid_ready", {63'h0, ready_o}, 64'h1);
    chk("rmid_done",  {63'h0, done_o},  64'h0);
    @(negedge clk_i);
    chk("rmid_done2", {63'h0, done_o},  64'h0);
    chk("rmid_cyc2",  {63'h0, cyc_o},   64'h0);

    // Address wrap at the top of the address space
    start(1'b0, 32'hFFFF_FFFE, 8'h0F, 1'b0, 64'h0);
    beat("wrap1", 32'hFFFF_FFF8, 8'hC0, 1'b0, 64'h0, 64'h0, 64'hBBAA_0000_0000_0000, 1'b0, 0);
    beat("wrap2", 32'h0000_0000, 8'h03, 1'b0, 64'h0, 64'h0, 64'h0000_0000_0000_DDCC, 1'b0, 0);
    finish("wrap", 1'b0, 64'h0000_0000_DDCC_BBAA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
